address_request_sequencer: RTL and testbench

Front-end sequencer sitting directly upstream of the associative address encoder. It accepts alloc/release requests for global addresses on a valid/ready handshake, runs the encoder's lookup → write/clear → re-lookup sequence, and returns the local slot id with a status code. It also generates the encoder's synchronous reset, hides the encoder's 2^output_width-cycle init phase, and tracks occupancy.

---
 rtl/address_request_sequencer_if.sv | 25 ++
 rtl/address_request_sequencer.sv | 170 +++++++++++++++++
 tb/tb_address_request_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/address_request_sequencer_if.sv
// Request/response handshake bundle between a client and address_request_sequencer.
// The client drives the master side; the sequencer implements the slave side.
interface address_request_sequencer_if #(
    parameter int input_width  = 16,
    parameter int output_width = 3
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_op;
    logic [input_width-1:0]  req_addr;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [output_width-1:0] rsp_id;
    logic [2:0]              rsp_status;

    modport master (
        output req_valid, req_op, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_status
    );

    modport slave (
        input  req_valid, req_op, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_status
    );
endinterface

// File: rtl/address_request_sequencer.sv
// Front-end sequencer for the associative address encoder: runs lookup/write-or-clear/
// re-lookup per request, hides the encoder reset and init phase, and tracks occupancy.
module address_request_sequencer #(
    parameter int output_width = 3,
    parameter int input_width  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    address_request_sequencer_if.slave req_bus,
    output logic [output_width:0]   occupancy,
    output logic                    enc_reset,
    output logic                    enc_we,
    output logic                    enc_clear,
    output logic [input_width-1:0]  enc_addr_in,
    input  logic [output_width-1:0] enc_addr_out,
    input  logic                    enc_not_selected,
    input  logic                    enc_address_conflict,
    input  logic                    enc_free_space
);

    localparam int init_cycles = (2 ** output_width) + 2;
    localparam logic [output_width:0] occ_max = {1'b1, {output_width{1'b0}}};

    typedef enum logic [2:0] {
        RST_SYNC, INIT, IDLE, LOOKUP, COMMIT, VERIFY, RESP
    } state_t;

    typedef enum logic [2:0] {
        ST_OK = 3'd0, ST_EXISTS = 3'd1, ST_FULL = 3'd2, ST_NOT_FOUND = 3'd3, ST_CONFLICT = 3'd4
    } status_t;

    typedef logic [output_width+1:0] cnt_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q;
    cnt_t                    init_cnt;
    logic                    op_q;
    logic [input_width-1:0]  addr_q;
    logic [output_width-1:0] slot_q;
    logic [output_width-1:0] rsp_id_q, rsp_id_d;
    status_t                 rsp_status_q, rsp_status_d;
    logic [output_width:0]   occ_q;
    logic                    enc_we_q, enc_clear_q;
    logic                    rsp_load, slot_load, we_d, clear_d, occ_inc, occ_dec;
    logic                    capture, hit;

    assign hit     = ~enc_not_selected;
    assign capture = (state_q == IDLE) && req_bus.req_valid;

    // NOTE: every flop here uses <= so all registers sample the pre-edge values together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            state_q      <= RST_SYNC;
            init_cnt     <= '0;
            op_q         <= 1'b0;
            addr_q       <= '0;
            slot_q       <= '0;
            rsp_id_q     <= '0;
            rsp_status_q <= ST_OK;
            occ_q        <= '0;
            enc_we_q     <= 1'b0;
            enc_clear_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], 1'b1};
            state_q     <= state_d;
            init_cnt    <= (state_q == INIT) ? init_cnt + 1'b1 : '0;
            enc_we_q    <= we_d;
            enc_clear_q <= clear_d;
            if (capture) begin
                op_q   <= req_bus.req_op;
                addr_q <= req_bus.req_addr;
            end
            if (slot_load) slot_q <= enc_addr_out;
            if (rsp_load) begin
                rsp_id_q     <= rsp_id_d;
                rsp_status_q <= rsp_status_d;
            end
            if (occ_inc && occ_q != occ_max)  occ_q <= occ_q + 1'b1;
            else if (occ_dec && occ_q != '0)  occ_q <= occ_q - 1'b1;
        end
    end

    // Encoder flags are combinational on enc_addr_in, which holds addr_q from LOOKUP onward.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST_SYNC: if (sync_q[0]) state_d = INIT;
            INIT:     if (init_cnt == cnt_t'(init_cycles - 1)) state_d = IDLE;
            IDLE:     if (req_bus.req_valid) state_d = LOOKUP;
            LOOKUP: begin
                if (enc_address_conflict)            state_d = RESP;
                else if (!op_q && (hit || !enc_free_space)) state_d = RESP;
                else if (op_q && !hit)               state_d = RESP;
                else                                 state_d = COMMIT;
            end
            COMMIT:   state_d = op_q ? RESP : VERIFY;
            VERIFY:   state_d = RESP;
            RESP:     if (req_bus.rsp_ready) state_d = IDLE;
            default:  state_d = RST_SYNC;
        endcase
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        rsp_load     = 1'b0;
        rsp_id_d     = '0;
        rsp_status_d = ST_OK;
        slot_load    = 1'b0;
        we_d         = 1'b0;
        clear_d      = 1'b0;
        occ_inc      = 1'b0;
        occ_dec      = 1'b0;
        req_bus.req_ready = (state_q == IDLE);
        req_bus.rsp_valid = (state_q == RESP);
        enc_addr_in  = (state_q == RST_SYNC || state_q == INIT) ? '0 : addr_q;
        unique case (state_q)
            LOOKUP: begin
                if (enc_address_conflict) begin
                    rsp_load     = 1'b1;
                    rsp_status_d = ST_CONFLICT;
                end else if (!op_q) begin
                    if (hit) begin
                        rsp_load     = 1'b1;
                        rsp_status_d = ST_EXISTS;
                        rsp_id_d     = enc_addr_out;
                    end else if (!enc_free_space) begin
                        rsp_load     = 1'b1;
                        rsp_status_d = ST_FULL;
                    end else begin
                        we_d = 1'b1;
                    end
                end else if (!hit) begin
                    rsp_load     = 1'b1;
                    rsp_status_d = ST_NOT_FOUND;
                end else begin
                    slot_load = 1'b1;
                    clear_d   = 1'b1;
                end
            end
            COMMIT: begin
                if (op_q) begin
                    rsp_load     = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_id_d     = slot_q;
                    occ_dec      = 1'b1;
                end
            end
            VERIFY: begin
                rsp_load = 1'b1;
                if (hit && !enc_address_conflict) begin
                    rsp_status_d = ST_OK;
                    rsp_id_d     = enc_addr_out;
                    occ_inc      = 1'b1;
                end else begin
                    rsp_status_d = ST_CONFLICT;
                end
            end
            default: ;
        endcase
    end

    assign req_bus.rsp_id     = rsp_id_q;
    assign req_bus.rsp_status = rsp_status_q;
    assign occupancy          = occ_q;
    assign enc_reset          = ~sync_q[1];
    assign enc_we             = enc_we_q;
    assign enc_clear          = enc_clear_q;

endmodule

// File: tb/tb_address_request_sequencer.sv
// Scoreboard bench for address_request_sequencer with a behavioural 8-entry encoder model.
module tb_address_request_sequencer;

    localparam logic [2:0] S_OK = 3'd0, S_EXISTS = 3'd1, S_FULL = 3'd2,
                           S_NOT_FOUND = 3'd3, S_CONFLICT = 3'd4;

    logic        clk;
    logic        reset;
    logic [3:0]  occupancy;
    logic        enc_reset, enc_we, enc_clear;
    logic [15:0] enc_addr_in;
    logic [2:0]  enc_addr_out;
    logic        enc_not_selected, enc_address_conflict, enc_free_space;

    address_request_sequencer_if #(.input_width(16), .output_width(3)) bus ();

    address_request_sequencer #(.output_width(3), .input_width(16)) dut (
        .clock                (clk),
        .reset                (reset),
        .req_bus              (bus),
        .occupancy            (occupancy),
        .enc_reset            (enc_reset),
        .enc_we               (enc_we),
        .enc_clear            (enc_clear),
        .enc_addr_in          (enc_addr_in),
        .enc_addr_out         (enc_addr_out),
        .enc_not_selected     (enc_not_selected),
        .enc_address_conflict (enc_address_conflict),
        .enc_free_space       (enc_free_space)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder model: lowest free slot on write, forced conflict on 0x00AA.
    logic        ent_v [8];
    logic [15:0] ent_a [8];
    int          m_hits, m_idx, m_free, wslot;

    always_comb begin
        m_hits = 0;
        m_idx  = 0;
        m_free = 0;
        for (int i = 0; i < 8; i++) begin
            if (!ent_v[i]) m_free = 1;
            if (ent_v[i] && ent_a[i] == enc_addr_in) begin
                if (m_hits == 0) m_idx = i;
                m_hits = m_hits + 1;
            end
        end
        enc_addr_out         = m_idx[2:0];
        enc_not_selected     = (m_hits == 0);
        enc_free_space       = (m_free != 0);
        enc_address_conflict = (m_hits > 1) || (enc_addr_in == 16'h00AA);
    end

    always @(posedge clk) begin
        if (enc_reset) begin
            for (int i = 0; i < 8; i++) ent_v[i] <= 1'b0;
        end else if (enc_we) begin
            wslot = -1;
            for (int i = 0; i < 8; i++) if (!ent_v[i] && wslot < 0) wslot = i;
            if (wslot >= 0) begin
                ent_v[wslot] <= 1'b1;
                ent_a[wslot] <= enc_addr_in;
            end
        end else if (enc_clear) begin
            for (int i = 0; i < 8; i++) if (ent_v[i] && ent_a[i] == enc_addr_in) ent_v[i] <= 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] status;
        logic [2:0] id;
        int         lat;
        int         we;
        int         clr;
        int         occ;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency and strobe counts from handshake edge to rsp_valid rising.
    int   hs_edge = 0, we_cnt = 0, clr_cnt = 0;
    logic rsp_prev = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) begin
            hs_edge = cyc + 1;
            we_cnt  = 0;
            clr_cnt = 0;
        end
        if (enc_we) we_cnt++;
        if (enc_clear) clr_cnt++;
        if (enc_we && enc_clear) begin
            checks++;
            errors++;
            $display("FAIL we_clear_exclusive: both strobes high at cycle %0d", cyc);
        end
        if (bus.rsp_valid && !rsp_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: status %0d id %0d with empty scoreboard",
                         bus.rsp_status, bus.rsp_id);
            end else begin
                e = sb.pop_front();
                check("rsp_status", 32'(bus.rsp_status), 32'(e.status));
                check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                check("latency", 32'(cyc - hs_edge + 1), 32'(e.lat));
                check("we_pulses", 32'(we_cnt), 32'(e.we));
                check("clear_pulses", 32'(clr_cnt), 32'(e.clr));
                check("occupancy", 32'(occupancy), 32'(e.occ));
            end
        end
        rsp_prev = bus.rsp_valid;
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: req_ready not seen within 40 cycles", name);
        end
    endtask

    task automatic do_req(input logic op, input logic [15:0] addr, input logic [2:0] st,
                          input logic [2:0] id, input int lat, input int we, input int clr,
                          input int occ, input bit hold);
        exp_t x;
        int   n;
        x.status = st; x.id = id; x.lat = lat; x.we = we; x.clr = clr; x.occ = occ;
        sb.push_back(x);
        bus.rsp_ready = !hold;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        wait_ready("req_handshake");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no response for addr %h", addr);
            return;
        end
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("hold_rsp_id", 32'(bus.rsp_id), 32'(id));
                check("hold_rsp_status", 32'(bus.rsp_status), 32'(st));
                check("hold_req_ready", 32'(bus.req_ready), 32'd0);
                @(posedge clk); #1;
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        check({tag, "_rsp_status"}, 32'(bus.rsp_status), 32'd0);
        check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
        check({tag, "_enc_we"}, 32'(enc_we), 32'd0);
        check({tag, "_enc_clear"}, 32'(enc_clear), 32'd0);
        check({tag, "_enc_addr_in"}, 32'(enc_addr_in), 32'd0);
        check({tag, "_enc_reset"}, 32'(enc_reset), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_edge, rdy_edge;
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_addr  = 16'h4321;
        bus.rsp_ready = 1'b1;
        #3 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_values("por");

        // Release with req_valid held: count edges to enc_reset fall and first req_ready.
        reset     = 1'b1;
        fall_edge = -1;
        rdy_edge  = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (!enc_reset && fall_edge < 0) fall_edge = i;
            if (bus.req_ready && rdy_edge < 0) begin
                rdy_edge      = i;
                bus.req_valid = 1'b0;
                check("no_capture_in_init", 32'(enc_addr_in), 32'd0);
            end
        end
        check("enc_reset_fall_edge", 32'(fall_edge), 32'd2);
        check("first_ready_edge", 32'(rdy_edge), 32'd12);

        do_req(1'b0, 16'h1234, S_OK, 3'd0, 4, 1, 0, 1, 1'b0);
        do_req(1'b0, 16'hBEEF, S_OK, 3'd1, 4, 1, 0, 2, 1'b0);
        do_req(1'b0, 16'h1234, S_EXISTS, 3'd0, 2, 0, 0, 2, 1'b0);
        do_req(1'b1, 16'h1234, S_OK, 3'd0, 3, 0, 1, 1, 1'b0);
        do_req(1'b1, 16'hBEEF, S_OK, 3'd1, 3, 0, 1, 0, 1'b0);

        for (int i = 0; i < 8; i++)
            do_req(1'b0, 16'(16'h0100 + i), S_OK, i[2:0], 4, 1, 0, i + 1, 1'b0);
        do_req(1'b0, 16'h0108, S_FULL, 3'd0, 2, 0, 0, 8, 1'b0);
        do_req(1'b1, 16'h0999, S_NOT_FOUND, 3'd0, 2, 0, 0, 8, 1'b0);

        do_req(1'b0, 16'h00AA, S_CONFLICT, 3'd0, 2, 0, 0, 8, 1'b0);
        do_req(1'b1, 16'h00AA, S_CONFLICT, 3'd0, 2, 0, 0, 8, 1'b0);

        do_req(1'b1, 16'h0103, S_OK, 3'd3, 3, 0, 1, 7, 1'b0);
        do_req(1'b0, 16'h5555, S_OK, 3'd3, 4, 1, 0, 8, 1'b1);

        // Reset asserted while the release of 0x0100 sits in COMMIT.
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b1;
        bus.req_addr  = 16'h0100;
        wait_ready("mid_reset_handshake");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("commit_clear_strobe", 32'(enc_clear), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_values("mid");
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        wait_ready("reinit_ready");
        check("reinit_occupancy", 32'(occupancy), 32'd0);
        check("reinit_enc_reset", 32'(enc_reset), 32'd0);

        do_req(1'b0, 16'h1234, S_OK, 3'd0, 4, 1, 0, 1, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
